bus_load_decoder: RTL and testbench

Destination side of the datapath bus: decodes IR register fields and load strobes into one-hot register enables and captures the bus value into the target register on the clock edge. Holds R0–R15, HI, LO, Zhigh, Zlow, PC and MDR. Drives their values, plus the 16-bit register-out vector and the sign-extended constant, back to the source-side bus multiplexer. This closes the bus loop: the multiplexer chooses who drives, and this block chooses who listens.

---
 rtl/bus_load_decoder_if.sv | 40 ++++
 rtl/bus_load_decoder.sv | 70 +++++++
 tb/tb_bus_load_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_load_decoder_if.sv
// bus_load_decoder_if: control strobes, bus/memory data and register taps between datapath and load decoder
interface bus_load_decoder_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0]   BusMuxOut;
    logic [31:0]        IR;
    logic               Gra, Grb, Grc;
    logic               Rin, Rout, BAout;
    logic               HIin, LOin, PCin, Zin;
    logic               MDRin, Read;
    logic [WIDTH-1:0]   Mdatain;
    logic [2*WIDTH-1:0] C;
    logic [WIDTH-1:0]   BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3;
    logic [WIDTH-1:0]   BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7;
    logic [WIDTH-1:0]   BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11;
    logic [WIDTH-1:0]   BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15;
    logic [WIDTH-1:0]   BusMuxIn_HI, BusMuxIn_LO, BusMuxIn_Zhigh, BusMuxIn_Zlow;
    logic [WIDTH-1:0]   BusMuxIn_PC, BusMuxIn_MDR;
    logic [15:0]        Routwire, Rin_vec;
    logic [WIDTH-1:0]   C_sign_extended;
    logic               gr_err;

    modport master (
        output BusMuxOut, IR, Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin, PCin, Zin,
               MDRin, Read, Mdatain, C,
        input  BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3, BusMuxIn_R4, BusMuxIn_R5,
               BusMuxIn_R6, BusMuxIn_R7, BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
               BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15, BusMuxIn_HI, BusMuxIn_LO,
               BusMuxIn_Zhigh, BusMuxIn_Zlow, BusMuxIn_PC, BusMuxIn_MDR, Routwire, Rin_vec,
               C_sign_extended, gr_err
    );

    modport slave (
        input  BusMuxOut, IR, Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin, PCin, Zin,
               MDRin, Read, Mdatain, C,
        output BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3, BusMuxIn_R4, BusMuxIn_R5,
               BusMuxIn_R6, BusMuxIn_R7, BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
               BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15, BusMuxIn_HI, BusMuxIn_LO,
               BusMuxIn_Zhigh, BusMuxIn_Zlow, BusMuxIn_PC, BusMuxIn_MDR, Routwire, Rin_vec,
               C_sign_extended, gr_err
    );
endinterface

// File: rtl/bus_load_decoder.sv
// bus_load_decoder: decodes IR register fields into load/drive enables and holds the bus destination registers
module bus_load_decoder #(parameter int WIDTH = 32) (
    input  logic              clock,
    input  logic              clear,
    bus_load_decoder_if.slave bus
);
    logic [WIDTH-1:0] r_gpr [16];
    logic [WIDTH-1:0] r_hi, r_lo, r_zhigh, r_zlow, r_pc, r_mdr;
    logic             r_gr_err;
    logic [3:0]       w_sel;
    logic [15:0]      w_dec, w_rin_vec;
    logic             w_multi, w_unused_ir;

    assign w_sel = ({4{bus.Gra}} & bus.IR[26:23]) | ({4{bus.Grb}} & bus.IR[22:19])
                 | ({4{bus.Grc}} & bus.IR[18:15]);
    assign w_dec = 16'(1) << w_sel;
    assign w_rin_vec = bus.Rin ? w_dec : '0;
    assign w_multi = ((bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc))
                   & (bus.Rin | bus.Rout | bus.BAout);
    assign w_unused_ir = ^bus.IR[31:27];

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int k = 0; k < 16; k++) r_gpr[k] <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_zhigh  <= '0;
            r_zlow   <= '0;
            r_pc     <= '0;
            r_mdr    <= '0;
            r_gr_err <= 1'b0;
        end else begin
            for (int k = 0; k < 16; k++) if (w_rin_vec[k]) r_gpr[k] <= bus.BusMuxOut;
            if (bus.HIin) r_hi <= bus.BusMuxOut;
            if (bus.LOin) r_lo <= bus.BusMuxOut;
            if (bus.PCin) r_pc <= bus.BusMuxOut;
            if (bus.Zin) {r_zhigh, r_zlow} <= bus.C;
            if (bus.MDRin) r_mdr <= bus.Read ? bus.Mdatain : bus.BusMuxOut;
            if (w_multi) r_gr_err <= 1'b1;
        end
    end

    assign bus.Rin_vec         = w_rin_vec;
    assign bus.Routwire        = (bus.Rout | bus.BAout) ? w_dec : '0;
    assign bus.C_sign_extended = {{(WIDTH-19){bus.IR[18]}}, bus.IR[18:0]};
    assign bus.gr_err          = r_gr_err;
    // R0 reads as zero while used as a base address, but its storage is untouched
    assign bus.BusMuxIn_R0     = bus.BAout ? '0 : r_gpr[0];
    assign bus.BusMuxIn_R1     = r_gpr[1];
    assign bus.BusMuxIn_R2     = r_gpr[2];
    assign bus.BusMuxIn_R3     = r_gpr[3];
    assign bus.BusMuxIn_R4     = r_gpr[4];
    assign bus.BusMuxIn_R5     = r_gpr[5];
    assign bus.BusMuxIn_R6     = r_gpr[6];
    assign bus.BusMuxIn_R7     = r_gpr[7];
    assign bus.BusMuxIn_R8     = r_gpr[8];
    assign bus.BusMuxIn_R9     = r_gpr[9];
    assign bus.BusMuxIn_R10    = r_gpr[10];
    assign bus.BusMuxIn_R11    = r_gpr[11];
    assign bus.BusMuxIn_R12    = r_gpr[12];
    assign bus.BusMuxIn_R13    = r_gpr[13];
    assign bus.BusMuxIn_R14    = r_gpr[14];
    assign bus.BusMuxIn_R15    = r_gpr[15];
    assign bus.BusMuxIn_HI     = r_hi;
    assign bus.BusMuxIn_LO     = r_lo;
    assign bus.BusMuxIn_Zhigh  = r_zhigh;
    assign bus.BusMuxIn_Zlow   = r_zlow;
    assign bus.BusMuxIn_PC     = r_pc;
    assign bus.BusMuxIn_MDR    = r_mdr;
endmodule

// File: tb/tb_bus_load_decoder.sv
// tb_bus_load_decoder: directed stimulus with a per-cycle reference model and literal spot checks
module tb_bus_load_decoder;
    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    bus_load_decoder_if bus ();
    bus_load_decoder dut (.clock(clk), .clear(clear), .bus(bus));

    int checks = 0;
    int failures = 0;
    bit en = 1'b0;
    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_zh, m_zl, m_pc, m_mdr;
    bit          m_err;
    logic [31:0] dut_r [16];

    assign dut_r[0]  = bus.BusMuxIn_R0;
    assign dut_r[1]  = bus.BusMuxIn_R1;
    assign dut_r[2]  = bus.BusMuxIn_R2;
    assign dut_r[3]  = bus.BusMuxIn_R3;
    assign dut_r[4]  = bus.BusMuxIn_R4;
    assign dut_r[5]  = bus.BusMuxIn_R5;
    assign dut_r[6]  = bus.BusMuxIn_R6;
    assign dut_r[7]  = bus.BusMuxIn_R7;
    assign dut_r[8]  = bus.BusMuxIn_R8;
    assign dut_r[9]  = bus.BusMuxIn_R9;
    assign dut_r[10] = bus.BusMuxIn_R10;
    assign dut_r[11] = bus.BusMuxIn_R11;
    assign dut_r[12] = bus.BusMuxIn_R12;
    assign dut_r[13] = bus.BusMuxIn_R13;
    assign dut_r[14] = bus.BusMuxIn_R14;
    assign dut_r[15] = bus.BusMuxIn_R15;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int f_sel();
        int s = 0;
        if (bus.Gra) s = s | int'(bus.IR[26:23]);
        if (bus.Grb) s = s | int'(bus.IR[22:19]);
        if (bus.Grc) s = s | int'(bus.IR[18:15]);
        return s;
    endfunction

    always @(posedge clk) begin
        int s;
        int n;
        if (clear) begin
            for (int k = 0; k < 16; k++) m_r[k] = 0;
            {m_hi, m_lo, m_zh, m_zl, m_pc, m_mdr} = '0;
            m_err = 1'b0;
            en = 1'b1;
        end else begin
            s = f_sel();
            n = int'(bus.Gra) + int'(bus.Grb) + int'(bus.Grc);
            if (bus.Rin) m_r[s] = bus.BusMuxOut;
            if (bus.HIin) m_hi = bus.BusMuxOut;
            if (bus.LOin) m_lo = bus.BusMuxOut;
            if (bus.PCin) m_pc = bus.BusMuxOut;
            if (bus.Zin) begin
                m_zh = bus.C[63:32];
                m_zl = bus.C[31:0];
            end
            if (bus.MDRin) m_mdr = bus.Read ? bus.Mdatain : bus.BusMuxOut;
            if (n >= 2 && (bus.Rin || bus.Rout || bus.BAout)) m_err = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [15:0] d;
        logic [31:0] se;
        if (en) begin
            d  = 16'(1) << f_sel();
            se = 32'($signed(bus.IR[18:0]));
            chk("rin_vec", 64'(bus.Rin_vec), 64'(bus.Rin ? d : 16'h0));
            chk("routwire", 64'(bus.Routwire), 64'((bus.Rout || bus.BAout) ? d : 16'h0));
            chk("c_sign_ext", 64'(bus.C_sign_extended), 64'(se));
            for (int k = 0; k < 16; k++)
                chk($sformatf("r%0d", k), 64'(dut_r[k]), 64'((k == 0 && bus.BAout) ? 32'h0 : m_r[k]));
            chk("hi", 64'(bus.BusMuxIn_HI), 64'(m_hi));
            chk("lo", 64'(bus.BusMuxIn_LO), 64'(m_lo));
            chk("zhigh", 64'(bus.BusMuxIn_Zhigh), 64'(m_zh));
            chk("zlow", 64'(bus.BusMuxIn_Zlow), 64'(m_zl));
            chk("pc", 64'(bus.BusMuxIn_PC), 64'(m_pc));
            chk("mdr", 64'(bus.BusMuxIn_MDR), 64'(m_mdr));
            chk("gr_err", 64'(bus.gr_err), 64'(m_err));
        end
    end

    task automatic idle();
        bus.BusMuxOut = '0; bus.IR = '0; bus.Mdatain = '0; bus.C = '0;
        {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout} = '0;
        {bus.HIin, bus.LOin, bus.PCin, bus.Zin, bus.MDRin, bus.Read} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        tick();
        tick();
        clear = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idle();
            bus.Gra = 1'b1; bus.IR = 32'(k) << 23; bus.Rin = 1'b1; bus.BusMuxOut = 32'h100 + 32'(k);
            tick();
        end
        idle();
        bus.BusMuxOut = 32'h55; bus.HIin = 1'b1; bus.LOin = 1'b1; bus.PCin = 1'b1; bus.MDRin = 1'b1;
        bus.Zin = 1'b1; bus.C = 64'h1111_2222_3333_4444;
        tick();
        idle();
        bus.Gra = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1; bus.BusMuxOut = 32'h66;
        tick();
        idle();
        #1 chk("lit_err_set", 64'(bus.gr_err), 64'd1);
        chk("lit_r9_fill", 64'(bus.BusMuxIn_R9), 64'h109);
        // clear must win over every strobe asserted alongside it
        clear = 1'b1; bus.Gra = 1'b1; bus.IR = 32'(9) << 23; bus.Rin = 1'b1;
        bus.BusMuxOut = 32'hFFFF_FFFF; bus.HIin = 1'b1; bus.Zin = 1'b1; bus.C = '1;
        tick();
        clear = 1'b0;
        idle();
        #1 chk("lit_rst_r9", 64'(bus.BusMuxIn_R9), 64'h0);
        chk("lit_rst_r3", 64'(bus.BusMuxIn_R3), 64'h0);
        chk("lit_rst_hi", 64'(bus.BusMuxIn_HI), 64'h0);
        chk("lit_rst_zh", 64'(bus.BusMuxIn_Zhigh), 64'h0);
        chk("lit_rst_mdr", 64'(bus.BusMuxIn_MDR), 64'h0);
        chk("lit_rst_err", 64'(bus.gr_err), 64'h0);
        bus.Gra = 1'b1; bus.IR = 32'(5) << 23; bus.Rin = 1'b1; bus.BusMuxOut = 32'hDEAD_BEEF;
        #1 chk("lit_rin_vec5", 64'(bus.Rin_vec), 64'h0020);
        chk("lit_r5_before", 64'(bus.BusMuxIn_R5), 64'h0);
        tick();
        idle();
        #1 chk("lit_r5", 64'(bus.BusMuxIn_R5), 64'hDEAD_BEEF);
        chk("lit_r4", 64'(bus.BusMuxIn_R4), 64'h0);
        bus.Gra = 1'b1; bus.Rin = 1'b1; bus.BusMuxOut = 32'h1234;
        tick();
        idle();
        bus.Grb = 1'b1; bus.BAout = 1'b1;
        #1 chk("lit_r0_ba", 64'(bus.BusMuxIn_R0), 64'h0);
        chk("lit_rout_ba", 64'(bus.Routwire), 64'h0001);
        tick();
        bus.BAout = 1'b0;
        #1 chk("lit_r0_noba", 64'(bus.BusMuxIn_R0), 64'h1234);
        bus.BAout = 1'b1; bus.Rin = 1'b1; bus.BusMuxOut = 32'h77;
        tick();
        idle();
        #1 chk("lit_r0_write_ba", 64'(bus.BusMuxIn_R0), 64'h77);
        bus.IR = (32'(2) << 23) | (32'(1) << 15); bus.Gra = 1'b1; bus.Grc = 1'b1; bus.Rout = 1'b1;
        #1 chk("lit_rout_multi", 64'(bus.Routwire), 64'h0008);
        tick();
        idle();
        #1 chk("lit_err_multi", 64'(bus.gr_err), 64'd1);
        tick();
        tick();
        chk("lit_err_sticky", 64'(bus.gr_err), 64'd1);
        bus.Gra = 1'b1; bus.Grb = 1'b1;
        tick();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1 chk("lit_err_clear", 64'(bus.gr_err), 64'd0);
        bus.Zin = 1'b1; bus.C = 64'h0000_0001_8000_0000;
        bus.MDRin = 1'b1; bus.Read = 1'b1; bus.Mdatain = 32'hA5A5_A5A5; bus.BusMuxOut = 32'h0;
        tick();
        idle();
        #1 chk("lit_zhigh", 64'(bus.BusMuxIn_Zhigh), 64'h1);
        chk("lit_zlow", 64'(bus.BusMuxIn_Zlow), 64'h8000_0000);
        chk("lit_mdr_read", 64'(bus.BusMuxIn_MDR), 64'hA5A5_A5A5);
        bus.Read = 1'b1; bus.Mdatain = 32'hFFFF_0000; bus.BusMuxOut = 32'h42;
        tick();
        bus.MDRin = 1'b1; bus.Read = 1'b0;
        #1 chk("lit_mdr_noload", 64'(bus.BusMuxIn_MDR), 64'hA5A5_A5A5);
        tick();
        idle();
        #1 chk("lit_mdr_bus", 64'(bus.BusMuxIn_MDR), 64'h42);
        bus.IR = 32'h0004_0000;
        #1 chk("lit_sext_neg", 64'(bus.C_sign_extended), 64'hFFFC_0000);
        bus.IR = 32'h0003_FFFF;
        #1 chk("lit_sext_pos", 64'(bus.C_sign_extended), 64'h0003_FFFF);
        tick();
        idle();
        bus.Grb = 1'b1; bus.IR = 32'(7) << 19; bus.Rin = 1'b1; bus.BusMuxOut = 32'h11;
        tick();
        bus.Rout = 1'b1; bus.BusMuxOut = 32'h22;
        #1 chk("lit_rmw_pre", 64'(bus.BusMuxIn_R7), 64'h11);
        tick();
        idle();
        #1 chk("lit_rmw_post", 64'(bus.BusMuxIn_R7), 64'h22);
        for (int k = 0; k < 3; k++) begin
            bus.Grc = 1'b1; bus.IR = 32'(12) << 15; bus.Rin = 1'b1; bus.BusMuxOut = 32'hC00 + 32'(k);
            bus.HIin = 1'b1; bus.LOin = 1'b1; bus.PCin = 1'b1; bus.MDRin = 1'b1;
            tick();
        end
        idle();
        #1 chk("lit_hold_r12", 64'(bus.BusMuxIn_R12), 64'hC02);
        chk("lit_sim_pc", 64'(bus.BusMuxIn_PC), 64'hC02);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
